// File: rtl/can_data_field_seq.sv
// CAN / CAN FD data-field sequencer.
// Takes the DLC at the end of the control field and turns it into a byte count.
// Collects destuffed data bits into bytes and writes each byte to the RX buffer.
// Flags the end of the data field and picks the CRC type used by the CRC stage.
//
// Handshake: there is no backpressure. dlc_valid, bit_valid and abort are
// single-cycle qualifiers, and their data is sampled on the same rising edge.
// byte_wr and data_done are single-cycle strobes, and their data is stable
// while the strobe is high.

// DLC to byte-count decoder, using the 0..8/12/16/20/24/32/48/64 mapping.
module can_dlc_decoder (
  input  logic [3:0] dlc_i,
  input  logic       fd_i,
  output logic [6:0] len_o
);

  // Classic frames saturate at 8 bytes. FD frames use the extended table above 8.
  always_comb begin
    len_o = 7'd0;
    if (dlc_i <= 4'd8) begin
      len_o = {3'b000, dlc_i};
    end else if (!fd_i) begin
      len_o = 7'd8;
    end else begin
      case (dlc_i)
        4'd9:    len_o = 7'd12;
        4'd10:   len_o = 7'd16;
        4'd11:   len_o = 7'd20;
        4'd12:   len_o = 7'd24;
        4'd13:   len_o = 7'd32;
        4'd14:   len_o = 7'd48;
        default: len_o = 7'd64;
      endcase
    end
  end

endmodule

module can_data_field_seq #(
  parameter int FD_ENABLE = 1,
  parameter int ADDR_W    = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dlc_valid,
  input  logic [3:0]        dlc_in,
  input  logic              fd_frame_in,
  input  logic              bit_valid,
  input  logic              bit_in,
  input  logic              abort,
  output logic [6:0]        data_len_out,
  output logic [1:0]        crc_type,
  output logic              in_data,
  output logic              byte_wr,
  output logic [ADDR_W-1:0] byte_addr,
  output logic [7:0]        byte_out,
  output logic              data_done,
  output logic              dbg_state_o
);

  typedef enum logic {IDLE = 1'b0, DATA = 1'b1} state_t;

  localparam logic FD_EN = (FD_ENABLE != 0);

  state_t            state_q;
  logic [6:0]        len_q;
  logic [1:0]        crc_q;
  logic              in_data_q;
  logic              byte_wr_q;
  logic [ADDR_W-1:0] byte_addr_q;
  logic [7:0]        byte_out_q;
  logic              data_done_q;
  logic [2:0]        bit_cnt_q;
  logic [ADDR_W-1:0] byte_cnt_q;
  logic [7:0]        shift_q;

  logic              fd_eff;
  logic [6:0]        dec_len;
  logic [1:0]        crc_d;
  logic [7:0]        shift_d;
  logic              last_byte;

  // When FD support is disabled, the FDF bit is ignored and every frame decodes as classic.
  assign fd_eff = FD_EN & fd_frame_in;

  can_dlc_decoder u_dec (
    .dlc_i (dlc_in),
    .fd_i  (fd_eff),
    .len_o (dec_len)
  );

  // CRC selection: CRC21 for long FD payloads, CRC17 for other FD frames, CRC15 for classic.
  always_comb begin
    crc_d = 2'b00;
    if (fd_eff && (dec_len > 7'd16)) crc_d = 2'b10;
    else if (fd_eff)                 crc_d = 2'b01;
  end

  // The first bit received moves up to the MSB after eight shifts.
  assign shift_d   = {shift_q[6:0], bit_in};
  assign last_byte = ((7'(byte_cnt_q) + 7'd1) == len_q);

  // Frame FSM. All outputs are registered. abort takes priority over any bit or DLC event.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= 7'd0;
      crc_q       <= 2'b00;
      in_data_q   <= 1'b0;
      byte_wr_q   <= 1'b0;
      byte_addr_q <= '0;
      byte_out_q  <= 8'd0;
      data_done_q <= 1'b0;
      bit_cnt_q   <= 3'd0;
      byte_cnt_q  <= '0;
      shift_q     <= 8'd0;
    end else begin
      byte_wr_q   <= 1'b0;
      data_done_q <= 1'b0;
      if (abort) begin
        state_q    <= IDLE;
        in_data_q  <= 1'b0;
        bit_cnt_q  <= 3'd0;
        byte_cnt_q <= '0;
        shift_q    <= 8'd0;
      end else begin
        case (state_q)
          IDLE: begin
            if (dlc_valid) begin
              len_q      <= dec_len;
              crc_q      <= crc_d;
              bit_cnt_q  <= 3'd0;
              byte_cnt_q <= '0;
              shift_q    <= 8'd0;
              if (dec_len == 7'd0) begin
                data_done_q <= 1'b1;
              end else begin
                state_q   <= DATA;
                in_data_q <= 1'b1;
              end
            end
          end
          DATA: begin
            if (bit_valid) begin
              shift_q   <= shift_d;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                byte_wr_q   <= 1'b1;
                byte_out_q  <= shift_d;
                byte_addr_q <= byte_cnt_q;
                byte_cnt_q  <= byte_cnt_q + ADDR_W'(1);
                if (last_byte) begin
                  data_done_q <= 1'b1;
                  state_q     <= IDLE;
                  in_data_q   <= 1'b0;
                end
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign data_len_out = len_q;
  assign crc_type     = crc_q;
  assign in_data      = in_data_q;
  assign byte_wr      = byte_wr_q;
  assign byte_addr    = byte_addr_q;
  assign byte_out     = byte_out_q;
  assign data_done    = data_done_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_can_data_field_seq.sv
// Bench for can_data_field_seq.
// Two instances receive the same stimulus: one is FD-capable and one is classic only.
// A frame-level model predicts the outputs of both instances on every cycle.
// A queue of hand-computed bytes is checked against the writes of the FD instance.
module tb_can_data_field_seq;

  localparam int AW = 6;

  logic clk = 1'b0;
  logic rst, dlc_valid, fd_frame_in, bit_valid, bit_in, abort;
  logic [3:0] dlc_in;

  logic [6:0]    len_o  [2];
  logic [1:0]    crc_o  [2];
  logic          ind_o  [2];
  logic          wr_o   [2];
  logic [AW-1:0] addr_o [2];
  logic [7:0]    out_o  [2];
  logic          done_o [2];
  logic          st_o   [2];

  int total = 0;
  int bad   = 0;
  int n_wr  = 0;
  int n_done = 0;
  int last_done_addr = -1;
  bit chk_en = 1'b0;
  logic [13:0] exp_q[$];

  // model state, index 0 = FD-capable instance, 1 = classic-only instance
  bit m_act[2];
  int m_len[2], m_nb[2], m_cur[2];
  int e_len[2], e_crc[2], e_in[2], e_wr[2], e_addr[2], e_out[2], e_done[2];
  int fd_tab[16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 12, 16, 20, 24, 32, 48, 64};

  always #5 clk = ~clk;

  can_data_field_seq #(.FD_ENABLE(1), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .dlc_valid(dlc_valid), .dlc_in(dlc_in),
    .fd_frame_in(fd_frame_in), .bit_valid(bit_valid), .bit_in(bit_in), .abort(abort),
    .data_len_out(len_o[0]), .crc_type(crc_o[0]), .in_data(ind_o[0]), .byte_wr(wr_o[0]),
    .byte_addr(addr_o[0]), .byte_out(out_o[0]), .data_done(done_o[0]), .dbg_state_o(st_o[0])
  );

  can_data_field_seq #(.FD_ENABLE(0), .ADDR_W(AW)) dut_c (
    .clk(clk), .rst(rst), .dlc_valid(dlc_valid), .dlc_in(dlc_in),
    .fd_frame_in(fd_frame_in), .bit_valid(bit_valid), .bit_in(bit_in), .abort(abort),
    .data_len_out(len_o[1]), .crc_type(crc_o[1]), .in_data(ind_o[1]), .byte_wr(wr_o[1]),
    .byte_addr(addr_o[1]), .byte_out(out_o[1]), .data_done(done_o[1]), .dbg_state_o(st_o[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, act, exp);
    end
  endtask

  // frame-level model: counts bits per frame and emits a byte after every eighth bit
  initial begin
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 0; m_len[k] = 0; m_nb[k] = 0; m_cur[k] = 0;
      e_len[k] = 0; e_crc[k] = 0; e_in[k] = 0; e_wr[k] = 0;
      e_addr[k] = 0; e_out[k] = 0; e_done[k] = 0;
    end
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        bit fdk;
        int l;
        fdk = (k == 0) ? fd_frame_in : 1'b0;
        e_wr[k] = 0;
        e_done[k] = 0;
        if (rst) begin
          m_act[k] = 0; m_nb[k] = 0; m_cur[k] = 0;
          e_len[k] = 0; e_crc[k] = 0; e_addr[k] = 0; e_out[k] = 0;
        end else if (abort) begin
          m_act[k] = 0; m_nb[k] = 0; m_cur[k] = 0;
        end else if (!m_act[k]) begin
          if (dlc_valid) begin
            l = fdk ? fd_tab[dlc_in] : ((dlc_in > 8) ? 8 : int'(dlc_in));
            e_len[k] = l;
            e_crc[k] = !fdk ? 0 : ((l > 16) ? 2 : 1);
            m_len[k] = l; m_nb[k] = 0; m_cur[k] = 0;
            if (l == 0) e_done[k] = 1;
            else m_act[k] = 1;
          end
        end else if (bit_valid) begin
          m_cur[k] = m_cur[k] * 2 + int'(bit_in);
          m_nb[k]++;
          if (m_nb[k] % 8 == 0) begin
            e_wr[k] = 1;
            e_out[k] = m_cur[k] % 256;
            e_addr[k] = m_nb[k] / 8 - 1;
            m_cur[k] = 0;
            if (m_nb[k] / 8 == m_len[k]) begin
              e_done[k] = 1;
              m_act[k] = 0;
            end
          end
        end
        e_in[k] = m_act[k];
      end
    end
  end

  // compare process: every output of both instances on every cycle, plus the write scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int k = 0; k < 2; k++) begin
          string p;
          p = (k == 0) ? "fd" : "cl";
          chk({p, "_len"},  32'(len_o[k]),  32'(e_len[k]));
          chk({p, "_crc"},  32'(crc_o[k]),  32'(e_crc[k]));
          chk({p, "_in"},   32'(ind_o[k]),  32'(e_in[k]));
          chk({p, "_wr"},   32'(wr_o[k]),   32'(e_wr[k]));
          chk({p, "_addr"}, 32'(addr_o[k]), 32'(e_addr[k]));
          chk({p, "_out"},  32'(out_o[k]),  32'(e_out[k]));
          chk({p, "_done"}, 32'(done_o[k]), 32'(e_done[k]));
        end
        if (wr_o[0] === 1'b1) begin
          n_wr++;
          if (exp_q.size() == 0) begin
            chk("sb_unexpected_wr", 32'(addr_o[0]), 32'hFFFF);
          end else begin
            logic [13:0] e;
            e = exp_q.pop_front();
            chk("sb_byte", {18'd0, addr_o[0], out_o[0]}, {18'd0, e});
          end
        end
        if (done_o[0] === 1'b1) begin
          n_done++;
          last_done_addr = (wr_o[0] === 1'b1) ? int'(addr_o[0]) : -2;
        end
      end
    end
  end

  task automatic cyc(input logic dv, input logic [3:0] dl, input logic fd,
                     input logic bv, input logic b, input logic ab, input logic r);
    @(negedge clk);
    dlc_valid = dv; dlc_in = dl; fd_frame_in = fd;
    bit_valid = bv; bit_in = b; abort = ab; rst = r;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 4'd0, 0, 0, 0, 0, 0);
  endtask

  task automatic dlc(input logic [3:0] d, input logic fd);
    cyc(1, d, fd, 0, 0, 0, 0);
  endtask

  task automatic send_byte(input logic [7:0] v, input int addr, input int gap);
    exp_q.push_back({6'(addr), v});
    for (int i = 7; i >= 0; i--) begin
      cyc(0, 4'd0, 0, 1, v[i], 0, 0);
      if (gap > 0) idle(gap);
    end
  endtask

  initial begin
    int w0, d0;
    logic [7:0] t1 [8];
    t1 = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    cyc(0, 4'd0, 0, 0, 0, 0, 1);
    cyc(0, 4'd0, 0, 0, 0, 0, 1);
    chk_en = 1'b1;
    idle(1);
    chk("rst_len", 32'(len_o[0]), 32'd0);
    chk("rst_addr", 32'(addr_o[0]), 32'd0);
    chk("rst_in_data", 32'(ind_o[0]), 32'd0);

    // bits while idle must be ignored
    cyc(0, 4'd0, 0, 1, 1, 0, 0);
    cyc(0, 4'd0, 0, 1, 0, 0, 0);

    // 1: classic frame, DLC 15 -> 8 bytes, alternate gaps between bits
    w0 = n_wr;
    dlc(4'hF, 0);
    for (int i = 0; i < 8; i++) send_byte(t1[i], i, i % 2);
    idle(3);
    chk("t1_len", 32'(len_o[0]), 32'd8);
    chk("t1_crc", 32'(crc_o[0]), 32'd0);
    chk("t1_nwr", 32'(n_wr - w0), 32'd8);
    chk("t1_done_addr", 32'(last_done_addr), 32'd7);

    // 2: FD DLC 13 -> 32 bytes of A5, bits back to back
    w0 = n_wr;
    dlc(4'hD, 1);
    for (int i = 0; i < 32; i++) send_byte(8'hA5, i, 0);
    idle(3);
    chk("t2_len", 32'(len_o[0]), 32'd32);
    chk("t2_crc", 32'(crc_o[0]), 32'd2);
    chk("t2_nwr", 32'(n_wr - w0), 32'd32);
    chk("t2_done_addr", 32'(last_done_addr), 32'd31);

    // 3: FD DLC 10 -> 16 bytes, CRC17; the classic instance sees 8 bytes, CRC15.
    // A stray dlc_valid mid-frame must be ignored by both instances.
    dlc(4'hA, 1);
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(i * 17 + 3), i, 0);
      if (i == 2) dlc(4'h1, 0);
    end
    idle(3);
    chk("t3_len", 32'(len_o[0]), 32'd16);
    chk("t3_crc", 32'(crc_o[0]), 32'd1);
    chk("t3_cl_len", 32'(len_o[1]), 32'd8);
    chk("t3_cl_crc", 32'(crc_o[1]), 32'd0);

    // 4: zero-length frame
    w0 = n_wr; d0 = n_done;
    dlc(4'h0, 0);
    idle(3);
    chk("t4_ndone", 32'(n_done - d0), 32'd1);
    chk("t4_nwr", 32'(n_wr - w0), 32'd0);
    chk("t4_len", 32'(len_o[0]), 32'd0);

    // 5: abort on the 8th bit of byte 3, then a fresh 2-byte frame
    w0 = n_wr; d0 = n_done;
    dlc(4'hF, 1);
    for (int i = 0; i < 3; i++) send_byte(8'h3C + 8'(i), i, 0);
    for (int i = 7; i >= 1; i--) cyc(0, 4'd0, 0, 1, 1'(8'h96 >> i), 0, 0);
    cyc(0, 4'd0, 0, 1, 0, 1, 0);
    idle(2);
    chk("t5_nwr", 32'(n_wr - w0), 32'd3);
    chk("t5_ndone", 32'(n_done - d0), 32'd0);
    chk("t5_in_data", 32'(ind_o[0]), 32'd0);
    chk("t5_len_held", 32'(len_o[0]), 32'd64);
    dlc(4'h2, 1);
    send_byte(8'h5A, 0, 0);
    send_byte(8'hC3, 1, 0);
    idle(3);
    chk("t5_done_addr", 32'(last_done_addr), 32'd1);

    // 6: reset in the middle of byte 5 with bit_valid high every cycle
    dlc(4'h8, 1);
    for (int i = 0; i < 5; i++) send_byte(8'hF0 ^ 8'(i), i, 0);
    for (int i = 0; i < 4; i++) cyc(0, 4'd0, 0, 1, 1, 0, 0);
    cyc(0, 4'd0, 0, 1, 1, 0, 1);
    idle(1);
    chk("t6_len", 32'(len_o[0]), 32'd0);
    chk("t6_out", 32'(out_o[0]), 32'd0);
    chk("t6_addr", 32'(addr_o[0]), 32'd0);
    chk("t6_in_data", 32'(ind_o[0]), 32'd0);
    dlc(4'h1, 0);
    send_byte(8'h81, 0, 0);
    idle(3);
    chk("t6_done_addr", 32'(last_done_addr), 32'd0);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
